// File: rtl/wisecore_defs.sv
// Shared definitions for the wisecore memory subsystem: arbiter state
// encoding, pipeline stall-vector constants and bus widths.
package wisecore_defs;

  // Arbiter FSM states.
  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    IF_BUSY  = 2'd1,
    MEM_BUSY = 2'd2
  } arb_state_t;

  // Stall vector bit order is {wb, mem, ex, id, if, pc}.
  localparam int STALL_W = 6;
  localparam logic [STALL_W-1:0] STALL_NONE = 6'b000000;
  localparam logic [STALL_W-1:0] STALL_IF   = 6'b000011;
  localparam logic [STALL_W-1:0] STALL_MEM  = 6'b011111;

  // Bus geometry.
  localparam int BUS_AW = 32;
  localparam int BUS_DW = 32;
  localparam int BUS_SW = BUS_DW / 8;

endpackage

// File: rtl/bus_arbiter.sv
// Single-port bus arbiter between the fetch stage and the MEM stage.
// MEM has fixed priority; every transaction returns to IDLE, so there is
// always at least one idle bus cycle between two bus cycles. Bus cycles
// that wait too long for i_bus_ack are aborted with o_bus_err.
module bus_arbiter
  import wisecore_defs::*;
#(
  parameter int TIMEOUT = 16
) (
  input  logic                clk,
  input  logic                rst,
  // fetch port
  input  logic                i_if_req,
  input  logic [BUS_AW-1:0]   i_if_addr,
  output logic                o_if_ack,
  output logic [BUS_DW-1:0]   o_if_rdata,
  // data port
  input  logic                i_mem_req,
  input  logic                i_mem_we,
  input  logic [BUS_AW-1:0]   i_mem_addr,
  input  logic [BUS_SW-1:0]   i_mem_sel,
  input  logic [BUS_DW-1:0]   i_mem_wdata,
  output logic                o_mem_ack,
  output logic [BUS_DW-1:0]   o_mem_rdata,
  // bus side
  output logic                o_bus_ce,
  output logic                o_bus_we,
  output logic [BUS_AW-1:0]   o_bus_addr,
  output logic [BUS_SW-1:0]   o_bus_sel,
  output logic [BUS_DW-1:0]   o_bus_wdata,
  input  logic [BUS_DW-1:0]   i_bus_rdata,
  input  logic                i_bus_ack,
  output logic                o_bus_err,
  // pipeline stall vector
  output logic [STALL_W-1:0]  o_stall
);

  localparam int CW = $clog2(TIMEOUT);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  arb_state_t          r_state;
  arb_state_t          w_state_next;
  logic [CW-1:0]       r_cnt;
  logic                w_busy;
  logic                w_timeout;
  logic                w_done;

  logic                r_bus_ce;
  logic                r_bus_we;
  logic [BUS_AW-1:0]   r_bus_addr;
  logic [BUS_SW-1:0]   r_bus_sel;
  logic [BUS_DW-1:0]   r_bus_wdata;
  logic                r_if_ack;
  logic [BUS_DW-1:0]   r_if_rdata;
  logic                r_mem_ack;
  logic [BUS_DW-1:0]   r_mem_rdata;
  logic                r_bus_err;

  // A bus cycle ends on ack, or when the wait counter reaches its last
  // value without ack (an ack in that same cycle wins over the abort).
  assign w_busy    = (r_state == IF_BUSY) || (r_state == MEM_BUSY);
  assign w_timeout = w_busy && !i_bus_ack && (r_cnt == CNT_LAST);
  assign w_done    = w_busy && (i_bus_ack || w_timeout);

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic: MEM wins simultaneous requests; BUSY states exit on done.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE: begin
        if (i_mem_req) begin
          w_state_next = MEM_BUSY;
        end else if (i_if_req) begin
          w_state_next = IF_BUSY;
        end
      end
      IF_BUSY, MEM_BUSY: begin
        if (w_done) begin
          w_state_next = IDLE;
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  // Bus command, wait counter and completion registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt       <= '0;
      r_bus_ce    <= 1'b0;
      r_bus_we    <= 1'b0;
      r_bus_addr  <= '0;
      r_bus_sel   <= '0;
      r_bus_wdata <= '0;
      r_if_ack    <= 1'b0;
      r_if_rdata  <= '0;
      r_mem_ack   <= 1'b0;
      r_mem_rdata <= '0;
      r_bus_err   <= 1'b0;
    end else begin
      // Acks, rdata and err are single-cycle pulses by default.
      r_if_ack    <= 1'b0;
      r_if_rdata  <= '0;
      r_mem_ack   <= 1'b0;
      r_mem_rdata <= '0;
      r_bus_err   <= 1'b0;
      case (r_state)
        IDLE: begin
          r_cnt <= '0;
          if (i_mem_req) begin
            r_bus_ce    <= 1'b1;
            r_bus_we    <= i_mem_we;
            r_bus_addr  <= i_mem_addr;
            r_bus_sel   <= i_mem_sel;
            r_bus_wdata <= i_mem_wdata;
          end else if (i_if_req) begin
            r_bus_ce    <= 1'b1;
            r_bus_we    <= 1'b0;
            r_bus_addr  <= i_if_addr;
            r_bus_sel   <= '1;
            r_bus_wdata <= '0;
          end
        end
        IF_BUSY, MEM_BUSY: begin
          if (w_done) begin
            r_bus_ce  <= 1'b0;
            r_cnt     <= '0;
            r_bus_err <= w_timeout;
            if (r_state == IF_BUSY) begin
              r_if_ack   <= 1'b1;
              r_if_rdata <= w_timeout ? '0 : i_bus_rdata;
            end else begin
              r_mem_ack   <= 1'b1;
              r_mem_rdata <= (w_timeout || r_bus_we) ? '0 : i_bus_rdata;
            end
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: begin
          r_bus_ce <= 1'b0;
          r_cnt    <= '0;
        end
      endcase
    end
  end

  // Stall vector: MEM stall dominates; forced off while reset is asserted.
  always_comb begin
    o_stall = STALL_NONE;
    if (rst) begin
      o_stall = STALL_NONE;
    end else if (i_mem_req && !r_mem_ack) begin
      o_stall = STALL_MEM;
    end else if (i_if_req && !r_if_ack) begin
      o_stall = STALL_IF;
    end
  end

  assign o_bus_ce    = r_bus_ce;
  assign o_bus_we    = r_bus_we;
  assign o_bus_addr  = r_bus_addr;
  assign o_bus_sel   = r_bus_sel;
  assign o_bus_wdata = r_bus_wdata;
  assign o_if_ack    = r_if_ack;
  assign o_if_rdata  = r_if_rdata;
  assign o_mem_ack   = r_mem_ack;
  assign o_mem_rdata = r_mem_rdata;
  assign o_bus_err   = r_bus_err;

endmodule

// File: tb/tb_bus_arbiter.sv
// Self-checking bench for bus_arbiter. Expected behaviour is derived at the
// transaction level: a request granted from IDLE drives the bus from the
// next cycle; a bus ack in relative cycle k completes in k+1, otherwise the
// cycle is aborted and completes in TO+1 with err and zero rdata.
module tb_bus_arbiter;

  localparam int TO = 8;

  logic        clk;
  logic        rst;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_ack;
  logic [31:0] if_rdata;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_sel;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        bus_ce;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [3:0]  bus_sel;
  logic [31:0] bus_wdata;
  logic [31:0] bus_rdata;
  logic        bus_ack;
  logic        bus_err;
  logic [5:0]  stall;

  int checks = 0;
  int errors = 0;

  bus_arbiter #(.TIMEOUT(TO)) dut (
    .clk        (clk),
    .rst        (rst),
    .i_if_req   (if_req),
    .i_if_addr  (if_addr),
    .o_if_ack   (if_ack),
    .o_if_rdata (if_rdata),
    .i_mem_req  (mem_req),
    .i_mem_we   (mem_we),
    .i_mem_addr (mem_addr),
    .i_mem_sel  (mem_sel),
    .i_mem_wdata(mem_wdata),
    .o_mem_ack  (mem_ack),
    .o_mem_rdata(mem_rdata),
    .o_bus_ce   (bus_ce),
    .o_bus_we   (bus_we),
    .o_bus_addr (bus_addr),
    .o_bus_sel  (bus_sel),
    .o_bus_wdata(bus_wdata),
    .i_bus_rdata(bus_rdata),
    .i_bus_ack  (bus_ack),
    .o_bus_err  (bus_err),
    .o_stall    (stall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference stall rule: a pending MEM access stalls everything up to mem,
  // else a pending fetch stalls pc and if.
  function automatic logic [5:0] exp_stall(input logic mreq, input logic ireq,
                                           input logic mack, input logic iack);
    if (mreq && !mack) return 6'b011111;
    if (ireq && !iack) return 6'b000011;
    return 6'b000000;
  endfunction

  // Runs one granted transaction starting from its request cycle (cycle 0,
  // already in progress). lat = relative cycle of the bus ack (> TO: none
  // in time). rd = data the bus returns with its ack.
  task automatic run_txn(input bit is_mem, input int lat, input logic [31:0] rd,
                         input bit drop_early);
    logic [31:0] e_addr;
    logic [31:0] e_wdata;
    logic [31:0] e_rd;
    logic [3:0]  e_sel;
    logic        e_we;
    bit          to;
    int          e;
    e_addr  = is_mem ? mem_addr : if_addr;
    e_we    = is_mem ? mem_we : 1'b0;
    e_sel   = is_mem ? mem_sel : 4'hF;
    e_wdata = mem_wdata;
    to      = (lat > TO);
    e       = to ? TO + 1 : lat + 1;
    e_rd    = 32'h0;
    $display("txn %s we=%0b addr=%h sel=%h lat=%0d timeout=%0b",
             is_mem ? "MEM" : "IF ", e_we, e_addr, e_sel, lat, to);
    for (int n = 1; n <= e; n++) begin
      @(posedge clk); #1;
      bus_ack   = (n == lat);
      bus_rdata = (n == lat) ? rd : $urandom;
      if (n == lat && !to && !(is_mem && e_we)) e_rd = rd;
      if (drop_early && n == 1) begin
        if (is_mem) mem_req = 1'b0; else if_req = 1'b0;
      end
      @(negedge clk);
      if (n < e) begin
        checks++; if (bus_ce !== 1'b1) begin errors++; $display("FAIL busy_ce n=%0d got %b exp 1", n, bus_ce); end
        checks++; if (bus_addr !== e_addr) begin errors++; $display("FAIL busy_addr n=%0d got %h exp %h", n, bus_addr, e_addr); end
        checks++; if (bus_we !== e_we) begin errors++; $display("FAIL busy_we n=%0d got %b exp %b", n, bus_we, e_we); end
        checks++; if (bus_sel !== e_sel) begin errors++; $display("FAIL busy_sel n=%0d got %h exp %h", n, bus_sel, e_sel); end
        if (is_mem) begin
          checks++; if (bus_wdata !== e_wdata) begin errors++; $display("FAIL busy_wdata n=%0d got %h exp %h", n, bus_wdata, e_wdata); end
        end
        checks++; if ({mem_ack, if_ack, bus_err} !== 3'b000) begin errors++; $display("FAIL busy_pulses n=%0d got %b exp 000", n, {mem_ack, if_ack, bus_err}); end
      end else begin
        checks++; if (bus_ce !== 1'b0) begin errors++; $display("FAIL done_ce got %b exp 0", bus_ce); end
        checks++; if (mem_ack !== is_mem) begin errors++; $display("FAIL done_mem_ack got %b exp %b", mem_ack, is_mem); end
        checks++; if (if_ack !== !is_mem) begin errors++; $display("FAIL done_if_ack got %b exp %b", if_ack, !is_mem); end
        checks++; if (bus_err !== to) begin errors++; $display("FAIL done_err got %b exp %b", bus_err, to); end
        if (is_mem) begin
          checks++; if (mem_rdata !== e_rd) begin errors++; $display("FAIL done_mem_rdata got %h exp %h", mem_rdata, e_rd); end
        end else begin
          checks++; if (if_rdata !== e_rd) begin errors++; $display("FAIL done_if_rdata got %h exp %h", if_rdata, e_rd); end
        end
      end
      checks++;
      if (stall !== exp_stall(mem_req, if_req, (n == e) && is_mem, (n == e) && !is_mem)) begin
        errors++;
        $display("FAIL stall n=%0d got %b exp %b", n, stall,
                 exp_stall(mem_req, if_req, (n == e) && is_mem, (n == e) && !is_mem));
      end
      if (n == e) begin
        if (is_mem) mem_req = 1'b0; else if_req = 1'b0;
      end
    end
    bus_ack = 1'b0;
  endtask

  // Begin a fresh request cycle and check the stall it raises.
  task automatic start_req(input bit do_mem, input bit do_if);
    @(posedge clk); #1;
    if (do_mem) mem_req = 1'b1;
    if (do_if)  if_req  = 1'b1;
    @(negedge clk);
    checks++;
    if (stall !== exp_stall(mem_req, if_req, 1'b0, 1'b0)) begin
      errors++; $display("FAIL req_stall got %b exp %b", stall, exp_stall(mem_req, if_req, 1'b0, 1'b0));
    end
  endtask

  task automatic test_reset;
    @(negedge clk);
    checks++; if (bus_ce !== 1'b0) begin errors++; $display("FAIL rst_ce got %b exp 0", bus_ce); end
    checks++; if ({bus_we, bus_addr, bus_sel, bus_wdata} !== 69'h0) begin errors++; $display("FAIL rst_cmd got %h exp 0", {bus_we, bus_addr, bus_sel, bus_wdata}); end
    checks++; if ({if_ack, mem_ack, bus_err} !== 3'b000) begin errors++; $display("FAIL rst_pulses got %b exp 000", {if_ack, mem_ack, bus_err}); end
    checks++; if ({if_rdata, mem_rdata} !== 64'h0) begin errors++; $display("FAIL rst_rdata got %h exp 0", {if_rdata, mem_rdata}); end
    checks++; if (stall !== 6'b000000) begin errors++; $display("FAIL rst_stall got %b exp 000000", stall); end
  endtask

  task automatic test_fetch;
    if_addr = 32'h0000_0010;
    start_req(1'b0, 1'b1);
    run_txn(1'b0, 1, 32'h3401_1100, 1'b0);
  endtask

  task automatic test_collision;
    mem_we = 1'b1; mem_addr = 32'h0000_0100; mem_wdata = 32'hDEAD_BEEF; mem_sel = 4'b0011;
    if_addr = 32'h0000_0014;
    start_req(1'b1, 1'b1);
    run_txn(1'b1, 2, 32'h1234_5678, 1'b0);
    run_txn(1'b0, 1, 32'hCAFE_0001, 1'b0);
  endtask

  task automatic test_wait_states;
    mem_we = 1'b0; mem_addr = 32'h0000_0200; mem_sel = 4'b1111; mem_wdata = 32'h0;
    start_req(1'b1, 1'b0);
    run_txn(1'b1, 5, 32'h0BAD_F00D, 1'b0);
    // ack in the last allowed cycle still counts as a normal completion
    if_addr = 32'h0000_0040;
    start_req(1'b0, 1'b1);
    run_txn(1'b0, TO, 32'h5555_AAAA, 1'b0);
  endtask

  task automatic test_timeout;
    mem_we = 1'b0; mem_addr = 32'h0000_0300; mem_sel = 4'b1111;
    start_req(1'b1, 1'b0);
    run_txn(1'b1, TO + 1, 32'hFFFF_FFFF, 1'b0);
    if_addr = 32'h0000_0080;
    start_req(1'b0, 1'b1);
    run_txn(1'b0, 1000, 32'h0, 1'b0);
  endtask

  task automatic test_drop_req;
    if_addr = 32'h0000_00C0;
    start_req(1'b0, 1'b1);
    run_txn(1'b0, 3, 32'h7777_0000, 1'b1);
  endtask

  task automatic test_reset_mid;
    mem_we = 1'b1; mem_addr = 32'h0000_0400; mem_sel = 4'hF; mem_wdata = 32'h0101_0101;
    start_req(1'b1, 1'b0);
    $display("txn MEM reset in cycle 2");
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    checks++; if (bus_ce !== 1'b0) begin errors++; $display("FAIL midrst_ce got %b exp 0", bus_ce); end
    checks++; if (stall !== 6'b000000) begin errors++; $display("FAIL midrst_stall got %b exp 000000", stall); end
    checks++; if ({mem_ack, if_ack, bus_err} !== 3'b000) begin errors++; $display("FAIL midrst_pulses got %b exp 000", {mem_ack, if_ack, bus_err}); end
    mem_req = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++; if ({bus_ce, mem_ack, if_ack, bus_err} !== 4'b0000) begin errors++; $display("FAIL postrst_quiet i=%0d got %b exp 0000", i, {bus_ce, mem_ack, if_ack, bus_err}); end
      @(posedge clk); #1;
    end
    if_addr = 32'h0000_0500;
    start_req(1'b0, 1'b1);
    run_txn(1'b0, 1, 32'h600D_CAFE, 1'b0);
  endtask

  task automatic test_spurious_ack;
    $display("txn none spurious bus ack");
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      bus_ack = 1'b1;
      bus_rdata = $urandom;
      @(negedge clk);
      checks++; if ({bus_ce, mem_ack, if_ack, bus_err} !== 4'b0000) begin errors++; $display("FAIL spurious i=%0d got %b exp 0000", i, {bus_ce, mem_ack, if_ack, bus_err}); end
    end
    bus_ack = 1'b0;
    mem_we = 1'b0; mem_addr = 32'h0000_0600; mem_sel = 4'b0100;
    start_req(1'b1, 1'b0);
    run_txn(1'b1, 1, 32'hABCD_0123, 1'b0);
  endtask

  task automatic test_random;
    int pat;
    for (int it = 0; it < 40; it++) begin
      pat       = $urandom_range(2, 0);
      mem_we    = 1'($urandom);
      mem_addr  = $urandom;
      mem_sel   = 4'($urandom);
      mem_wdata = $urandom;
      if_addr   = $urandom & 32'hFFFF_FFFC;
      start_req(pat != 0, pat != 1);
      if (pat != 0) run_txn(1'b1, $urandom_range(TO + 2, 1), $urandom, 1'b0);
      if (pat != 1) run_txn(1'b0, $urandom_range(TO + 2, 1), $urandom, 1'b0);
    end
  endtask

  initial begin
    rst = 1'b1;
    if_req = 1'b0; if_addr = '0;
    mem_req = 1'b0; mem_we = 1'b0; mem_addr = '0; mem_sel = '0; mem_wdata = '0;
    bus_ack = 1'b0; bus_rdata = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    test_reset;
    test_fetch;
    test_collision;
    test_wait_states;
    test_timeout;
    test_drop_req;
    test_reset_mid;
    test_spurious_ack;
    test_random;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
